jk_lock_arbiter: RTL

//  Round-robin lock arbiter that shares one resource among N_REQ requesters.

---
 rtl/jk_lock_pkg.sv | 47 ++++
 rtl/jk_lock_arbiter_pick.sv | 42 ++++
 rtl/jk_lock_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/jk_lock_pkg.sv
// -----------------------------------------------------------------------------
// jk_lock_pkg
// Shared types and helpers for the J/K-style round-robin lock arbiter.
//   lock_state_t : ownership FSM state (IDLE, OWNED)
//   rr_pick_t    : result of a rotating-priority scan (found flag + index)
//   rr_first()   : rotating-priority scan over up to MAX_REQ requesters,
//                  starting at base, optionally skipping one index
// -----------------------------------------------------------------------------
package jk_lock_pkg;

   typedef enum logic {IDLE, OWNED} lock_state_t;

   // Upper bound on the number of requesters the scan helper supports.
   localparam int MAX_REQ = 16;
   localparam int MAX_IDW = 4;

   typedef struct packed {
      logic               found;
      logic [MAX_IDW-1:0] idx;
   } rr_pick_t;

   // Returns the first set req[i] for i = base, base+1, ... mod n_req.
   // When excl_en is set, index excl_idx is never chosen.
   // base is always < n_req, so one subtraction is enough for the wrap.
   function automatic rr_pick_t rr_first(input logic [MAX_REQ-1:0] req,
                                         input logic [MAX_IDW-1:0] base,
                                         input logic               excl_en,
                                         input logic [MAX_IDW-1:0] excl_idx,
                                         input int unsigned        n_req);
      rr_pick_t    r;
      int unsigned i;
      r.found = 1'b0;
      r.idx   = '0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         i = 32'(base) + k;
         if (i >= n_req) i = i - n_req;
         if ((k < n_req) && !r.found && (i < n_req)) begin
            if (req[i[3:0]] && !(excl_en && (i[3:0] == excl_idx))) begin
               r.found = 1'b1;
               r.idx   = i[3:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/jk_lock_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rr_pick_onehot
// Combinational rotating-priority picker shared by the IDLE grant path and the
// OWNED handoff path of jk_lock_arbiter.
// Ports:
//   req      in  N_REQ  candidate requests
//   base     in  IDW    index scanned first
//   excl_en  in  1      enable exclusion of excl_idx
//   excl_idx in  IDW    index never picked when excl_en=1
//   onehot   out N_REQ  one-hot of the chosen requester (0 if none)
//   idx      out IDW    index of the chosen requester (0 if none)
//   found    out 1      a requester was chosen
// -----------------------------------------------------------------------------
module rr_pick_onehot
   import jk_lock_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   base,
   input  logic             excl_en,
   input  logic [IDW-1:0]   excl_idx,
   output logic [N_REQ-1:0] onehot,
   output logic [IDW-1:0]   idx,
   output logic             found
);

   logic [MAX_REQ-1:0] req_w;
   rr_pick_t           pick;

   always_comb begin
      req_w            = '0;
      req_w[N_REQ-1:0] = req;
   end

   assign pick   = rr_first(req_w, MAX_IDW'(base), excl_en, MAX_IDW'(excl_idx), N_REQ);
   assign found  = pick.found;
   assign idx    = IDW'(pick.idx);
   assign onehot = N_REQ'(pick.found) << pick.idx;

endmodule

// File: rtl/jk_lock_arbiter.sv
// -----------------------------------------------------------------------------
// jk_lock_arbiter
// Round-robin lock arbiter sharing one single-owner resource among N_REQ
// requesters. Each requester claims with acq and releases with rel. Ownership
// lives in a registered two-state Moore FSM (IDLE / OWNED); on release with
// other claimants waiting, ownership is handed off at the same edge.
// Optional feature macro: LOCK_TIMEOUT_EN -- forces a release after the owner
// has held the lock for HOLD_MAX+1 cycles and pulses timeout_pulse.
// Ports:
//   clk            in   1      clock, rising edge
//   areset         in   1      asynchronous active-high reset
//   acq            in   N_REQ  per-requester claim (level)
//   rel            in   N_REQ  per-requester release (level)
//   grant          out  N_REQ  one-hot ownership, registered
//   busy           out  1      resource owned (== |grant)
//   owner_id       out  IDW    index of current/last owner, registered
//   timeout_pulse  out  1      1-cycle pulse after a forced release
// Handshake: acq/rel are levels sampled every rising edge; grant changes only
// on an edge; a requester owns the resource exactly while its grant bit is 1.
// The FSM state is held in state_q for checkers to observe.
// -----------------------------------------------------------------------------
module jk_lock_arbiter
   import jk_lock_pkg::*;
#(
   parameter  int N_REQ    = 4,
   parameter  int HOLD_MAX = 15,
   localparam int IDW      = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             areset,
   input  logic [N_REQ-1:0] acq,
   input  logic [N_REQ-1:0] rel,
   output logic [N_REQ-1:0] grant,
   output logic             busy,
   output logic [IDW-1:0]   owner_id,
   output logic             timeout_pulse
);

   lock_state_t      state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [IDW-1:0]   owner_q, owner_d;
   logic [IDW-1:0]   rr_q, rr_d;

   logic [IDW-1:0]   owner_inc;
   logic             rel_owner;
   logic             timeout_hit;

   logic [IDW-1:0]   pick_base;
   logic             pick_excl;
   logic [N_REQ-1:0] pick_onehot;
   logic [IDW-1:0]   pick_idx;
   logic             pick_found;

   assign owner_inc = (owner_q == IDW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
   assign rel_owner = rel[owner_q];

   // IDLE scans from the round-robin pointer; OWNED scans for a handoff target
   // starting just past the owner and never re-selects the owner itself.
   assign pick_base = (state_q == OWNED) ? owner_inc : rr_q;
   assign pick_excl = (state_q == OWNED);

   rr_pick_onehot #(.N_REQ(N_REQ)) u_pick (
      .req      (acq),
      .base     (pick_base),
      .excl_en  (pick_excl),
      .excl_idx (owner_q),
      .onehot   (pick_onehot),
      .idx      (pick_idx),
      .found    (pick_found)
   );

`ifdef LOCK_TIMEOUT_EN
   localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;

   logic [HW-1:0] hold_q, hold_d;
   logic          timeout_q;

   // The owner's own rel takes priority; the timeout only fires when it is absent.
   assign timeout_hit   = (state_q == OWNED) && (hold_q == HW'(HOLD_MAX)) && !rel_owner;
   assign timeout_pulse = timeout_q;
`else
   assign timeout_hit   = 1'b0;
   assign timeout_pulse = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      rr_d    = rr_q;
`ifdef LOCK_TIMEOUT_EN
      hold_d  = hold_q;
`endif
      case (state_q)
         IDLE: begin
            // rel is ignored here, so acq+rel on one requester still claims.
            if (pick_found) begin
               state_d = OWNED;
               grant_d = pick_onehot;
               owner_d = pick_idx;
`ifdef LOCK_TIMEOUT_EN
               hold_d  = '0;
`endif
            end
         end
         OWNED: begin
`ifdef LOCK_TIMEOUT_EN
            hold_d = hold_q + 1'b1;
`endif
            if (rel_owner || timeout_hit) begin
               rr_d = owner_inc;
`ifdef LOCK_TIMEOUT_EN
               hold_d = '0;
`endif
               if (pick_found) begin
                  grant_d = pick_onehot;
                  owner_d = pick_idx;
               end else begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
      end
   end

`ifdef LOCK_TIMEOUT_EN
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_hit;
      end
   end
`endif

   assign grant    = grant_q;
   assign busy     = |grant_q;
   assign owner_id = owner_q;

endmodule
